// File: rtl/fifo_skew_feeder.sv
// ============================================================================
//  Module      : fifo_skew_feeder
//  Description : Pops a bank of row FIFOs LEN times each with row i skewed by
//                i cycles, freezing the whole bank while any active row is
//                empty. Optional stall counter under FEED_STALL_CNT_EN.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module fifo_skew_feeder #(
    parameter int ROWS      = 32,
    parameter int ROWS_LOG2 = 5,
    parameter int LEN_W     = 8
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             START,
    input  logic [LEN_W-1:0] LEN,
    input  logic [ROWS-1:0]  FIFO_EMPTY,
    output logic [ROWS-1:0]  POPE,
    output logic [ROWS-1:0]  VALID,
    output logic             BUSY,
    output logic             DONE
`ifdef FEED_STALL_CNT_EN
    ,
    output logic [15:0]      STALL_CNT
`endif
);

    localparam int T_W = ROWS_LOG2 + LEN_W + 1;
    // Modular arithmetic keeps LEN+ROWS-2 correct even for ROWS==1 (LEN>=1 in RUN).
    localparam logic [T_W-1:0] c_last_off = T_W'(ROWS - 2);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_FIN  = 2'd2
    } state_t;

    state_t            r_state;
    state_t            w_next;
    logic [T_W-1:0]    r_t;
    logic [LEN_W-1:0]  r_len;
    logic [T_W-1:0]    w_len_ext;
    logic [ROWS-1:0]   w_active;
    logic              w_stall;
    logic              w_accept;
    logic              w_last;

    assign w_len_ext = {{(T_W-LEN_W){1'b0}}, r_len};
    assign w_accept  = (r_state == S_IDLE) && START;
    assign w_last    = (r_t == (w_len_ext + c_last_off));

    generate
        for (genvar i = 0; i < ROWS; i++) begin : g_row
            localparam logic [T_W-1:0] c_idx = T_W'(i);
            assign w_active[i] = (r_state == S_RUN) && (r_t >= c_idx) &&
                                 (r_t < (c_idx + w_len_ext));
        end
    endgenerate

    // Only rows inside their pop window can freeze the bank.
    assign w_stall = |(w_active & FIFO_EMPTY);

    always_ff @(posedge CLK) begin
        if (RST) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        POPE   = '0;
        VALID  = '0;
        BUSY   = 1'b0;
        DONE   = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (START) begin
                    w_next = (LEN == '0) ? S_FIN : S_RUN;
                end
            end
            S_RUN: begin
                BUSY  = 1'b1;
                POPE  = w_stall ? '0 : w_active;
                VALID = w_stall ? '0 : w_active;
                if (!w_stall && w_last) begin
                    w_next = S_FIN;
                end
            end
            S_FIN: begin
                BUSY   = 1'b1;
                DONE   = 1'b1;
                w_next = S_IDLE;
            end
            default: begin
                w_next = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            r_t   <= '0;
            r_len <= '0;
        end else if (w_accept) begin
            r_t   <= '0;
            r_len <= LEN;
        end else if ((r_state == S_RUN) && !w_stall) begin
            r_t   <= r_t + T_W'(1);
        end
    end

`ifdef FEED_STALL_CNT_EN
    logic [15:0] r_stall_cnt;

    always_ff @(posedge CLK) begin
        if (RST) begin
            r_stall_cnt <= '0;
        end else if (w_accept) begin
            r_stall_cnt <= '0;
        end else if ((r_state == S_RUN) && w_stall && (r_stall_cnt != 16'hFFFF)) begin
            r_stall_cnt <= r_stall_cnt + 16'd1;
        end
    end

    assign STALL_CNT = r_stall_cnt;
`endif

endmodule

`default_nettype wire

// File: tb/tb_fifo_skew_feeder.sv
// ============================================================================
//  Module      : tb_fifo_skew_feeder
//  Description : Directed self-checking bench for fifo_skew_feeder, ROWS=4.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_fifo_skew_feeder;

    logic       CLK;
    logic       RST;
    logic       START;
    logic [7:0] LEN;
    logic [3:0] FIFO_EMPTY;
    logic [3:0] POPE;
    logic [3:0] VALID;
    logic       BUSY;
    logic       DONE;
`ifdef FEED_STALL_CNT_EN
    logic [15:0] STALL_CNT;
`endif

    int n_cmp;
    int n_err;
    logic [3:0] exp_p [16];
    int pops [4];

    fifo_skew_feeder #(.ROWS(4), .ROWS_LOG2(2), .LEN_W(8)) dut (
        .CLK        (CLK),
        .RST        (RST),
        .START      (START),
        .LEN        (LEN),
        .FIFO_EMPTY (FIFO_EMPTY),
        .POPE       (POPE),
        .VALID      (VALID),
        .BUSY       (BUSY),
        .DONE       (DONE)
`ifdef FEED_STALL_CNT_EN
        ,
        .STALL_CNT  (STALL_CNT)
`endif
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    initial begin
        #100000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    // Entered at the start of cycle 1 of a pass; walks to DONE and back to IDLE.
    task automatic run_pass(input int done_cyc, input int emp_cyc, input logic [3:0] emp_mask,
                            input int jam_cyc, input int exp_pops);
        for (int r = 0; r < 4; r++) pops[r] = 0;
        for (int k = 1; k < done_cyc; k++) begin
            FIFO_EMPTY = (k == emp_cyc) ? emp_mask : 4'b0000;
            START      = (k == jam_cyc);
            if (k == jam_cyc) LEN = 8'd7;
            if (k == jam_cyc + 1) LEN = 8'd1;
            #1;
            chk($sformatf("pope@%0d", k), 32'(POPE), 32'(exp_p[k]));
            chk($sformatf("valid@%0d", k), 32'(VALID), 32'(exp_p[k]));
            chk($sformatf("busy@%0d", k), 32'(BUSY), 32'd1);
            chk($sformatf("done_lo@%0d", k), 32'(DONE), 32'd0);
            for (int r = 0; r < 4; r++) pops[r] += int'(POPE[r]);
            tick();
        end
        START      = 1'b0;
        FIFO_EMPTY = 4'b0000;
        #1;
        chk("done_pulse", 32'(DONE), 32'd1);
        chk("pope_fin", 32'(POPE), 32'd0);
        tick();
        chk("busy_idle", 32'(BUSY), 32'd0);
        chk("done_drop", 32'(DONE), 32'd0);
        for (int r = 0; r < 4; r++) chk($sformatf("pops_row%0d", r), 32'(pops[r]), 32'(exp_pops));
    endtask

    task automatic start_pass(input logic [7:0] len);
        START = 1'b1;
        LEN   = len;
        #1;
        chk("busy_c0", 32'(BUSY), 32'd0);
        tick();
        START = 1'b0;
    endtask

    initial begin
        n_cmp = 0;
        n_err = 0;
        RST = 1'b1;
        START = 1'b0;
        LEN = 8'd0;
        FIFO_EMPTY = 4'b0000;
        tick();
        tick();
        chk("rst_pope", 32'(POPE), 32'd0);
        chk("rst_valid", 32'(VALID), 32'd0);
        chk("rst_busy", 32'(BUSY), 32'd0);
        chk("rst_done", 32'(DONE), 32'd0);
`ifdef FEED_STALL_CNT_EN
        chk("rst_stallcnt", 32'(STALL_CNT), 32'd0);
`endif
        RST = 1'b0;
        tick();

        // Basic LEN=3 pass
        exp_p = '{4'h0, 4'h1, 4'h3, 4'h7, 4'hE, 4'hC, 4'h8, 4'h0,
                  4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0};
        start_pass(8'd3);
        run_pass(7, 0, 4'b0000, 0, 3);

        // Row 2 empty during cycle 3: one frozen cycle
        exp_p = '{4'h0, 4'h1, 4'h3, 4'h0, 4'h7, 4'hE, 4'hC, 4'h8,
                  4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0};
        start_pass(8'd3);
        run_pass(8, 3, 4'b0100, 0, 3);
`ifdef FEED_STALL_CNT_EN
        chk("stall_cnt", 32'(STALL_CNT), 32'd1);
`endif

        // Row 3 empty before it is active: no stall
        exp_p = '{4'h0, 4'h1, 4'h3, 4'h7, 4'hE, 4'hC, 4'h8, 4'h0,
                  4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0};
        start_pass(8'd3);
        run_pass(7, 2, 4'b1000, 0, 3);
`ifdef FEED_STALL_CNT_EN
        chk("stall_cnt_zero", 32'(STALL_CNT), 32'd0);
`endif

        // LEN=0: straight to FIN
        start_pass(8'd0);
        run_pass(1, 0, 4'b0000, 0, 0);

        // START pulsed and LEN changed mid-pass are ignored
        start_pass(8'd3);
        run_pass(7, 0, 4'b0000, 2, 3);

        // Reset mid-pass at cycle 4, then a clean LEN=2 pass
        start_pass(8'd3);
        for (int k = 1; k <= 3; k++) tick();
        RST = 1'b1;
        #1;
        chk("pre_rst_pope", 32'(POPE), 32'hE);
        tick();
        RST = 1'b0;
        START = 1'b1;
        LEN = 8'd2;
        #1;
        chk("post_rst_pope", 32'(POPE), 32'd0);
        chk("post_rst_busy", 32'(BUSY), 32'd0);
        tick();
        START = 1'b0;
        exp_p = '{4'h0, 4'h1, 4'h3, 4'h6, 4'hC, 4'h8, 4'h0, 4'h0,
                  4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0};
        run_pass(6, 0, 4'b0000, 0, 2);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

`default_nettype wire
